// File: rtl/ddr_rw_arbiter.sv
// Round-robin arbiter sharing one DDR burst read/write port between two clients.
// Optional burst watchdog enabled by defining ARB_WDOG_EN.
module ddr_rw_arbiter #(
  parameter real TCQ           = 0.1,
  parameter int  ADDR_WIDTH    = 28,
  parameter int  MEM_DATA_BITS = 512,
  parameter int  WDOG_CYCLES   = 65535
) (
  input  logic                     ddr_clk_i,
  input  logic                     ddr_rst_i,
  input  logic                     c0_wr_req_i,
  input  logic [7:0]               c0_wr_len_i,
  input  logic [ADDR_WIDTH-1:0]    c0_wr_addr_i,
  input  logic [MEM_DATA_BITS-1:0] c0_wr_data_i,
  output logic                     c0_fifo_rd_req_o,
  output logic                     c0_wr_finish_o,
  input  logic                     c0_rd_req_i,
  input  logic [7:0]               c0_rd_len_i,
  input  logic [ADDR_WIDTH-1:0]    c0_rd_addr_i,
  output logic                     c0_rd_data_valid_o,
  output logic [MEM_DATA_BITS-1:0] c0_rd_data_o,
  output logic                     c0_rd_finish_o,
  input  logic                     c1_wr_req_i,
  input  logic [7:0]               c1_wr_len_i,
  input  logic [ADDR_WIDTH-1:0]    c1_wr_addr_i,
  input  logic [MEM_DATA_BITS-1:0] c1_wr_data_i,
  output logic                     c1_fifo_rd_req_o,
  output logic                     c1_wr_finish_o,
  input  logic                     c1_rd_req_i,
  input  logic [7:0]               c1_rd_len_i,
  input  logic [ADDR_WIDTH-1:0]    c1_rd_addr_i,
  output logic                     c1_rd_data_valid_o,
  output logic [MEM_DATA_BITS-1:0] c1_rd_data_o,
  output logic                     c1_rd_finish_o,
  output logic                     wr_ddr_req_o,
  output logic [7:0]               wr_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]    wr_ddr_addr_o,
  input  logic                     ddr_fifo_rd_req_i,
  output logic [MEM_DATA_BITS-1:0] wr_ddr_data_o,
  input  logic                     wr_ddr_finish_i,
  output logic                     rd_ddr_req_o,
  output logic [7:0]               rd_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]    rd_ddr_addr_o,
  input  logic                     rd_ddr_data_valid_i,
  input  logic [MEM_DATA_BITS-1:0] rd_ddr_data_i,
  input  logic                     rd_ddr_finish_i,
  output logic                     busy_o
`ifdef ARB_WDOG_EN
  ,
  output logic                     wdog_err_o
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_GAP} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              ptr_q, gnt_q, sel_idx;
  logic [7:0]              len_q, sel_len;
  logic [ADDR_WIDTH-1:0]   addr_q, sel_addr;
  logic                    wr_req_q, rd_req_q;
  logic [3:0]              req_vec;
  logic                    any_req, grant, in_burst, timeout;

  // TCQ is retained for instantiation compatibility only; registers carry no delay.
  if (TCQ < 0.0 || WDOG_CYCLES < 1) begin : g_param_guard
  end

  assign req_vec  = {c1_rd_req_i, c1_wr_req_i, c0_rd_req_i, c0_wr_req_i};
  assign any_req  = |req_vec;
  assign grant    = (state_q == ST_IDLE) && any_req;
  assign in_burst = (state_q == ST_WR) || (state_q == ST_RD);

  always_comb begin
    logic       found;
    logic [1:0] cand;
    found   = 1'b0;
    cand    = ptr_q;
    sel_idx = ptr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req_vec[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    sel_len  = c0_wr_len_i;
    sel_addr = c0_wr_addr_i;
    case (sel_idx)
      2'd1:    begin sel_len = c0_rd_len_i; sel_addr = c0_rd_addr_i; end
      2'd2:    begin sel_len = c1_wr_len_i; sel_addr = c1_wr_addr_i; end
      2'd3:    begin sel_len = c1_rd_len_i; sel_addr = c1_rd_addr_i; end
      default: begin sel_len = c0_wr_len_i; sel_addr = c0_wr_addr_i; end
    endcase
  end

`ifdef ARB_WDOG_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES - 1);
  logic [15:0] wdog_cnt_q;
  logic        wdog_err_q;

  always_ff @(posedge ddr_clk_i) begin
    if (ddr_rst_i) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (grant)         wdog_cnt_q <= '0;
      else if (in_burst) wdog_cnt_q <= wdog_cnt_q + 16'd1;
      if (timeout)       wdog_err_q <= 1'b1;
    end
  end

  assign timeout    = in_burst && (wdog_cnt_q == WDOG_LIMIT);
  assign wdog_err_o = wdog_err_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge ddr_clk_i) begin
    if (ddr_rst_i) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = sel_idx[0] ? ST_RD : ST_WR;
      ST_WR:   if (wr_ddr_finish_i || timeout) state_d = ST_GAP;
      ST_RD:   if (rd_ddr_finish_i || timeout) state_d = ST_GAP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o             = 1'b0;
    c0_fifo_rd_req_o   = 1'b0;
    c1_fifo_rd_req_o   = 1'b0;
    c0_wr_finish_o     = 1'b0;
    c1_wr_finish_o     = 1'b0;
    c0_rd_data_valid_o = 1'b0;
    c1_rd_data_valid_o = 1'b0;
    c0_rd_finish_o     = 1'b0;
    c1_rd_finish_o     = 1'b0;
    case (state_q)
      ST_WR: begin
        busy_o           = 1'b1;
        c0_fifo_rd_req_o = ddr_fifo_rd_req_i && !gnt_q[1];
        c1_fifo_rd_req_o = ddr_fifo_rd_req_i &&  gnt_q[1];
        c0_wr_finish_o   = wr_ddr_finish_i   && !gnt_q[1];
        c1_wr_finish_o   = wr_ddr_finish_i   &&  gnt_q[1];
      end
      ST_RD: begin
        busy_o             = 1'b1;
        c0_rd_data_valid_o = rd_ddr_data_valid_i && !gnt_q[1];
        c1_rd_data_valid_o = rd_ddr_data_valid_i &&  gnt_q[1];
        c0_rd_finish_o     = rd_ddr_finish_i     && !gnt_q[1];
        c1_rd_finish_o     = rd_ddr_finish_i     &&  gnt_q[1];
      end
      default: ;
    endcase
  end

  // Grant registers; the controller request drops at the first beat or at finish.
  always_ff @(posedge ddr_clk_i) begin
    if (ddr_rst_i) begin
      ptr_q    <= '0;
      gnt_q    <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
    end else if (grant) begin
      ptr_q    <= sel_idx + 2'd1;
      gnt_q    <= sel_idx;
      len_q    <= sel_len;
      addr_q   <= sel_addr;
      wr_req_q <= !sel_idx[0];
      rd_req_q <=  sel_idx[0];
    end else begin
      if (state_q == ST_WR && (ddr_fifo_rd_req_i || wr_ddr_finish_i || timeout))
        wr_req_q <= 1'b0;
      if (state_q == ST_RD && (rd_ddr_data_valid_i || rd_ddr_finish_i || timeout))
        rd_req_q <= 1'b0;
    end
  end

  assign wr_ddr_req_o  = wr_req_q;
  assign rd_ddr_req_o  = rd_req_q;
  assign wr_ddr_len_o  = len_q;
  assign rd_ddr_len_o  = len_q;
  assign wr_ddr_addr_o = addr_q;
  assign rd_ddr_addr_o = addr_q;
  assign wr_ddr_data_o = gnt_q[1] ? c1_wr_data_i : c0_wr_data_i;
  assign c0_rd_data_o  = rd_ddr_data_i;
  assign c1_rd_data_o  = rd_ddr_data_i;

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Self-checking bench for ddr_rw_arbiter: vector table, scoreboard of expected grants,
// hand-written sequences for round-robin, simultaneous requests, reset and watchdog.
module tb_ddr_rw_arbiter;
  localparam int AW = 28;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          c0_wr_req, c0_rd_req, c1_wr_req, c1_rd_req;
  logic [7:0]    c0_wr_len, c0_rd_len, c1_wr_len, c1_rd_len;
  logic [AW-1:0] c0_wr_addr, c0_rd_addr, c1_wr_addr, c1_rd_addr;
  logic [DW-1:0] c0_wr_data, c1_wr_data, c0_rd_data, c1_rd_data;
  logic          c0_fifo_rd, c1_fifo_rd, c0_wr_fin, c1_wr_fin;
  logic          c0_rd_vld, c1_rd_vld, c0_rd_fin, c1_rd_fin;
  logic          wr_ddr_req, rd_ddr_req, busy;
  logic [7:0]    wr_ddr_len, rd_ddr_len;
  logic [AW-1:0] wr_ddr_addr, rd_ddr_addr;
  logic [DW-1:0] wr_ddr_data, rd_ddr_data;
  logic          fifo_rd_in, wr_fin_in, rd_vld_in, rd_fin_in;
`ifdef ARB_WDOG_EN
  logic          wdog_err;
`endif

  always #5 clk = ~clk;

  ddr_rw_arbiter #(.TCQ(0.1), .ADDR_WIDTH(AW), .MEM_DATA_BITS(DW), .WDOG_CYCLES(100)) dut (
    .ddr_clk_i(clk), .ddr_rst_i(rst),
    .c0_wr_req_i(c0_wr_req), .c0_wr_len_i(c0_wr_len), .c0_wr_addr_i(c0_wr_addr),
    .c0_wr_data_i(c0_wr_data), .c0_fifo_rd_req_o(c0_fifo_rd), .c0_wr_finish_o(c0_wr_fin),
    .c0_rd_req_i(c0_rd_req), .c0_rd_len_i(c0_rd_len), .c0_rd_addr_i(c0_rd_addr),
    .c0_rd_data_valid_o(c0_rd_vld), .c0_rd_data_o(c0_rd_data), .c0_rd_finish_o(c0_rd_fin),
    .c1_wr_req_i(c1_wr_req), .c1_wr_len_i(c1_wr_len), .c1_wr_addr_i(c1_wr_addr),
    .c1_wr_data_i(c1_wr_data), .c1_fifo_rd_req_o(c1_fifo_rd), .c1_wr_finish_o(c1_wr_fin),
    .c1_rd_req_i(c1_rd_req), .c1_rd_len_i(c1_rd_len), .c1_rd_addr_i(c1_rd_addr),
    .c1_rd_data_valid_o(c1_rd_vld), .c1_rd_data_o(c1_rd_data), .c1_rd_finish_o(c1_rd_fin),
    .wr_ddr_req_o(wr_ddr_req), .wr_ddr_len_o(wr_ddr_len), .wr_ddr_addr_o(wr_ddr_addr),
    .ddr_fifo_rd_req_i(fifo_rd_in), .wr_ddr_data_o(wr_ddr_data), .wr_ddr_finish_i(wr_fin_in),
    .rd_ddr_req_o(rd_ddr_req), .rd_ddr_len_o(rd_ddr_len), .rd_ddr_addr_o(rd_ddr_addr),
    .rd_ddr_data_valid_i(rd_vld_in), .rd_ddr_data_i(rd_ddr_data), .rd_ddr_finish_i(rd_fin_in),
    .busy_o(busy)
`ifdef ARB_WDOG_EN
    , .wdog_err_o(wdog_err)
`endif
  );

  typedef struct {
    logic          wr;
    logic          client;
    int            src;
    logic [7:0]    len;
    logic [AW-1:0] addr;
  } grant_t;

  grant_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_src(input int s, input logic r, input logic [7:0] l, input logic [AW-1:0] a);
    case (s)
      0: begin c0_wr_req = r; c0_wr_len = l; c0_wr_addr = a; end
      1: begin c0_rd_req = r; c0_rd_len = l; c0_rd_addr = a; end
      2: begin c1_wr_req = r; c1_wr_len = l; c1_wr_addr = a; end
      default: begin c1_rd_req = r; c1_rd_len = l; c1_rd_addr = a; end
    endcase
  endtask

  task automatic set_req(input int s, input logic r);
    case (s)
      0: c0_wr_req = r;
      1: c0_rd_req = r;
      2: c1_wr_req = r;
      default: c1_rd_req = r;
    endcase
  endtask

  task automatic push(input logic wr, input logic cl, input int s, input logic [7:0] l,
                      input logic [AW-1:0] a);
    grant_t g;
    g.wr = wr; g.client = cl; g.src = s; g.len = l; g.addr = a;
    sb.push_back(g);
  endtask

  // Acts as the burst controller for one grant, checking it against the scoreboard head.
  task automatic serve(input bit drop);
    grant_t        e;
    int            waited = 0;
    int            cnt_g = 0;
    int            cnt_o = 0;
    logic [DW-1:0] exp_d;
    while (!(wr_ddr_req || rd_ddr_req) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("grant_seen", wr_ddr_req | rd_ddr_req, 1'b1);
    if (!(wr_ddr_req || rd_ddr_req)) return;
    chk("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("grant_wr", wr_ddr_req, e.wr);
    chk("grant_rd", rd_ddr_req, !e.wr);
    chk("grant_len", e.wr ? wr_ddr_len : rd_ddr_len, e.len);
    chk("grant_addr", e.wr ? wr_ddr_addr : rd_ddr_addr, e.addr);
    chk("busy_grant", busy, 1'b1);
    set_src(e.src, 1'b1, ~e.len, ~e.addr);
    for (int b = 0; b < int'(e.len); b++) begin
      if (e.wr) begin
        c0_wr_data = rand_data();
        c1_wr_data = rand_data();
        exp_d      = e.client ? c1_wr_data : c0_wr_data;
        fifo_rd_in = 1'b1; rd_vld_in = 1'b1; rd_fin_in = 1'b1;
        #1;
        cnt_g += int'(e.client ? c1_fifo_rd : c0_fifo_rd);
        cnt_o += int'(e.client ? c0_fifo_rd : c1_fifo_rd);
        chk("wr_data_mux", wr_ddr_data, exp_d);
        chk("rd_strobes_dropped", {c0_rd_vld, c1_rd_vld, c0_rd_fin, c1_rd_fin}, 4'b0);
      end else begin
        exp_d       = rand_data();
        rd_ddr_data = exp_d;
        rd_vld_in = 1'b1; fifo_rd_in = 1'b1; wr_fin_in = 1'b1;
        #1;
        cnt_g += int'(e.client ? c1_rd_vld : c0_rd_vld);
        cnt_o += int'(e.client ? c0_rd_vld : c1_rd_vld);
        chk("rd_data", e.client ? c1_rd_data : c0_rd_data, exp_d);
        chk("wr_strobes_dropped", {c0_fifo_rd, c1_fifo_rd, c0_wr_fin, c1_wr_fin}, 4'b0);
      end
      @(negedge clk);
      if (b == 0) chk("req_clear_first_beat", wr_ddr_req | rd_ddr_req, 1'b0);
    end
    fifo_rd_in = 1'b0; rd_vld_in = 1'b0; rd_fin_in = 1'b0; wr_fin_in = 1'b0;
    chk("beats_granted", cnt_g, e.len);
    chk("beats_other", cnt_o, 0);
    chk("busy_before_finish", busy, 1'b1);
    chk("len_frozen", e.wr ? wr_ddr_len : rd_ddr_len, e.len);
    chk("addr_frozen", e.wr ? wr_ddr_addr : rd_ddr_addr, e.addr);
    set_src(e.src, 1'b1, e.len, e.addr);
    if (e.wr) wr_fin_in = 1'b1; else rd_fin_in = 1'b1;
    #1;
    if (e.wr) chk("wr_finish_route", {c1_wr_fin, c0_wr_fin}, e.client ? 2'b10 : 2'b01);
    else      chk("rd_finish_route", {c1_rd_fin, c0_rd_fin}, e.client ? 2'b10 : 2'b01);
    @(negedge clk);
    wr_fin_in = 1'b0; rd_fin_in = 1'b0;
    if (drop) set_req(e.src, 1'b0);
    chk("gap_busy", busy, 1'b0);
    chk("gap_reqs", {wr_ddr_req, rd_ddr_req}, 2'b0);
  endtask

  typedef struct {
    int            src;
    logic [7:0]    len;
    logic [AW-1:0] addr;
    logic          exp_wr;
    logic          exp_client;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int waited;
    vecs[0] = '{0, 8'd64, 28'h0000200, 1'b1, 1'b0};
    vecs[1] = '{3, 8'd8,  28'h0000400, 1'b0, 1'b1};
    vecs[2] = '{1, 8'd3,  28'h0001234, 1'b0, 1'b0};
    vecs[3] = '{2, 8'd5,  28'hFFFFFFF, 1'b1, 1'b1};
    vecs[4] = '{0, 8'd0,  28'h0000010, 1'b1, 1'b0};
    vecs[5] = '{3, 8'd90, 28'h0ABCDE0, 1'b0, 1'b1};

    rst = 1'b1;
    for (int s = 0; s < 4; s++) set_src(s, 1'b0, 8'd0, '0);
    c0_wr_data = '0; c1_wr_data = '0; rd_ddr_data = '0;
    fifo_rd_in = 1'b0; wr_fin_in = 1'b0; rd_vld_in = 1'b0; rd_fin_in = 1'b0;
    c0_wr_req = 1'b1;
    fifo_rd_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_reqs", {wr_ddr_req, rd_ddr_req}, 2'b0);
    chk("rst_len", {wr_ddr_len, rd_ddr_len}, 16'h0);
    chk("rst_addr", {wr_ddr_addr, rd_ddr_addr}, '0);
    chk("rst_strobes", {c0_fifo_rd, c1_fifo_rd}, 2'b0);
    c0_wr_req = 1'b0;
    fifo_rd_in = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      set_src(vecs[i].src, 1'b1, vecs[i].len, vecs[i].addr);
      push(vecs[i].exp_wr, vecs[i].exp_client, vecs[i].src, vecs[i].len, vecs[i].addr);
      serve(1'b1);
    end

    // Round robin with all four sources held high; pointer starts at 0.
    set_src(0, 1'b1, 8'd4, 28'h1000);
    set_src(1, 1'b1, 8'd4, 28'h2000);
    set_src(2, 1'b1, 8'd4, 28'h3000);
    set_src(3, 1'b1, 8'd4, 28'h4000);
    push(1'b1, 1'b0, 0, 8'd4, 28'h1000);
    push(1'b0, 1'b0, 1, 8'd4, 28'h2000);
    push(1'b1, 1'b1, 2, 8'd4, 28'h3000);
    push(1'b0, 1'b1, 3, 8'd4, 28'h4000);
    push(1'b1, 1'b0, 0, 8'd4, 28'h1000);
    for (int i = 0; i < 5; i++) serve(1'b0);
    for (int s = 0; s < 4; s++) set_req(s, 1'b0);
    repeat (2) @(negedge clk);
    chk("rr_idle_after", {busy, wr_ddr_req, rd_ddr_req}, 3'b0);

    // Pointer is 1; one c0_rd grant moves it to 2, then c0_wr and c1_wr collide.
    set_src(1, 1'b1, 8'd2, 28'h5000);
    push(1'b0, 1'b0, 1, 8'd2, 28'h5000);
    serve(1'b1);
    set_src(0, 1'b1, 8'd6, 28'h6000);
    set_src(2, 1'b1, 8'd7, 28'h7000);
    push(1'b1, 1'b1, 2, 8'd7, 28'h7000);
    push(1'b1, 1'b0, 0, 8'd6, 28'h6000);
    serve(1'b1);
    serve(1'b1);

    // Reset mid-burst; pointer is 1 beforehand, so a surviving pointer would pick c1_rd.
    set_src(0, 1'b1, 8'd20, 28'h80);
    waited = 0;
    while (!wr_ddr_req && waited < 50) begin @(negedge clk); waited++; end
    chk("rst_test_grant", wr_ddr_req, 1'b1);
    chk("rst_test_addr", wr_ddr_addr, 28'h80);
    fifo_rd_in = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    set_src(3, 1'b1, 8'd9, 28'h900);
    @(negedge clk);
    chk("midrst_reqs", {wr_ddr_req, rd_ddr_req}, 2'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_len_addr", {wr_ddr_len, wr_ddr_addr}, '0);
    chk("midrst_strobe_dropped", {c0_fifo_rd, c1_fifo_rd}, 2'b0);
    rst = 1'b0;
    fifo_rd_in = 1'b0;
    push(1'b1, 1'b0, 0, 8'd20, 28'h80);
    push(1'b0, 1'b1, 3, 8'd9, 28'h900);
    serve(1'b1);
    serve(1'b1);

`ifdef ARB_WDOG_EN
    set_src(1, 1'b1, 8'd4, 28'hA00);
    waited = 0;
    while (!rd_ddr_req && waited < 50) begin @(negedge clk); waited++; end
    chk("wdog_grant", rd_ddr_req, 1'b1);
    chk("wdog_err_clear", wdog_err, 1'b0);
    set_src(2, 1'b1, 8'd3, 28'hB00);
    waited = 0;
    while (!wdog_err && waited < 200) begin @(negedge clk); waited++; end
    chk("wdog_cycles", waited, 100);
    chk("wdog_busy", busy, 1'b0);
    chk("wdog_req_drop", rd_ddr_req, 1'b0);
    set_req(1, 1'b0);
    push(1'b1, 1'b1, 2, 8'd3, 28'hB00);
    serve(1'b1);
    chk("wdog_sticky", wdog_err, 1'b1);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
